// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker port between the instruction-side
// and data-side TLBs. Round-robin grant, one walk outstanding at a time, the
// response is routed back only to the owning TLB, and a watchdog forces an
// error response when the walker goes silent.
module ptw_arbiter #(
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             io_imem_req_valid,
  output logic             io_imem_req_ready,
  input  logic [VPN_W-1:0] io_imem_req_bits_vpn,
  output logic             io_imem_resp_valid,
  output logic             io_imem_resp_bits_error,
  output logic [PPN_W-1:0] io_imem_resp_bits_ppn,

  input  logic             io_dmem_req_valid,
  output logic             io_dmem_req_ready,
  input  logic [VPN_W-1:0] io_dmem_req_bits_vpn,
  output logic             io_dmem_resp_valid,
  output logic             io_dmem_resp_bits_error,
  output logic [PPN_W-1:0] io_dmem_resp_bits_ppn,

  output logic             io_ptw_req_valid,
  input  logic             io_ptw_req_ready,
  output logic [VPN_W-1:0] io_ptw_req_bits_vpn,
  input  logic             io_ptw_resp_valid,
  input  logic             io_ptw_resp_bits_error,
  input  logic [PPN_W-1:0] io_ptw_resp_bits_ppn,

  output logic             io_busy
);

  // A watchdog of 0 still needs a 1-bit timer so the declaration stays legal.
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TMR_ON = (TIMEOUT != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic OWN_IMEM = 1'b0;
  localparam logic OWN_DMEM = 1'b1;

  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic             last;
  logic             owner;
  logic [VPN_W-1:0] vpn_q;
  logic [PPN_W-1:0] ppn_q;
  logic             err_q;

  logic             grant_imem;
  logic             grant_dmem;
  logic             timeout_hit;

  // Round-robin grant in IDLE: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    grant_imem = 1'b0;
    grant_dmem = 1'b0;
    if ((state == S_IDLE) && !reset) begin
      if (io_imem_req_valid && io_dmem_req_valid) begin
        grant_imem = (last == OWN_DMEM);
        grant_dmem = (last == OWN_IMEM);
      end else begin
        grant_imem = io_imem_req_valid;
        grant_dmem = io_dmem_req_valid;
      end
    end
  end

  assign timeout_hit = TMR_ON && (timer == TMR_LAST);

  // Walk sequencing; a real walker response takes priority over an expiring watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
      last  <= OWN_DMEM;
      owner <= OWN_IMEM;
      vpn_q <= '0;
      ppn_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_imem || grant_dmem) begin
            owner <= grant_dmem ? OWN_DMEM : OWN_IMEM;
            vpn_q <= grant_dmem ? io_dmem_req_bits_vpn : io_imem_req_bits_vpn;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (io_ptw_req_ready) begin
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (io_ptw_resp_valid) begin
            err_q <= io_ptw_resp_bits_error;
            ppn_q <= io_ptw_resp_bits_ppn;
            state <= S_RESP;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            ppn_q <= '0;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          last  <= owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io_imem_req_ready       = grant_imem;
  assign io_dmem_req_ready       = grant_dmem;

  assign io_ptw_req_valid        = (state == S_REQ);
  assign io_ptw_req_bits_vpn     = vpn_q;

  assign io_imem_resp_valid      = (state == S_RESP) && (owner == OWN_IMEM);
  assign io_dmem_resp_valid      = (state == S_RESP) && (owner == OWN_DMEM);
  assign io_imem_resp_bits_error = err_q;
  assign io_dmem_resp_bits_error = err_q;
  assign io_imem_resp_bits_ppn   = ppn_q;
  assign io_dmem_resp_bits_ppn   = ppn_q;

  assign io_busy                 = (state != S_IDLE);

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter: plays both TLBs and the walker around ptw_arbiter. Each walk
// is predicted at transaction level (who wins, which VPN goes out, when and
// what comes back) from the arbitration and watchdog rules.
module tb_ptw_arbiter;

  localparam int VPN_W = 20;
  localparam int PPN_W = 32;
  localparam int TMO   = 8;
  localparam int TMO4  = 4;

  logic clk = 1'b0;
  logic reset;

  logic             imem_req_valid, dmem_req_valid;
  logic [VPN_W-1:0] imem_req_vpn, dmem_req_vpn;
  logic             ptw_req_ready, ptw_resp_valid, ptw_resp_err;
  logic [PPN_W-1:0] ptw_resp_ppn;

  logic             imem_req_ready, dmem_req_ready;
  logic             imem_resp_valid, dmem_resp_valid;
  logic             imem_resp_err, dmem_resp_err;
  logic [PPN_W-1:0] imem_resp_ppn, dmem_resp_ppn;
  logic             ptw_req_valid;
  logic [VPN_W-1:0] ptw_req_vpn;
  logic             busy;

  logic             t4_imem_req_ready, t4_dmem_req_ready;
  logic             t4_imem_resp_valid, t4_dmem_resp_valid;
  logic             t4_imem_resp_err, t4_dmem_resp_err;
  logic [PPN_W-1:0] t4_imem_resp_ppn, t4_dmem_resp_ppn;
  logic             t4_ptw_req_valid;
  logic [VPN_W-1:0] t4_ptw_req_vpn;
  logic             t4_busy;

  int   checks = 0;
  int   errors = 0;
  logic last_served;

  ptw_arbiter #(.VPN_W(VPN_W), .PPN_W(PPN_W), .TIMEOUT(TMO)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .io_imem_req_valid       (imem_req_valid),
    .io_imem_req_ready       (imem_req_ready),
    .io_imem_req_bits_vpn    (imem_req_vpn),
    .io_imem_resp_valid      (imem_resp_valid),
    .io_imem_resp_bits_error (imem_resp_err),
    .io_imem_resp_bits_ppn   (imem_resp_ppn),
    .io_dmem_req_valid       (dmem_req_valid),
    .io_dmem_req_ready       (dmem_req_ready),
    .io_dmem_req_bits_vpn    (dmem_req_vpn),
    .io_dmem_resp_valid      (dmem_resp_valid),
    .io_dmem_resp_bits_error (dmem_resp_err),
    .io_dmem_resp_bits_ppn   (dmem_resp_ppn),
    .io_ptw_req_valid        (ptw_req_valid),
    .io_ptw_req_ready        (ptw_req_ready),
    .io_ptw_req_bits_vpn     (ptw_req_vpn),
    .io_ptw_resp_valid       (ptw_resp_valid),
    .io_ptw_resp_bits_error  (ptw_resp_err),
    .io_ptw_resp_bits_ppn    (ptw_resp_ppn),
    .io_busy                 (busy)
  );

  // Second instance with a short watchdog, fed the same stimulus.
  ptw_arbiter #(.VPN_W(VPN_W), .PPN_W(PPN_W), .TIMEOUT(TMO4)) dut4 (
    .clk                     (clk),
    .reset                   (reset),
    .io_imem_req_valid       (imem_req_valid),
    .io_imem_req_ready       (t4_imem_req_ready),
    .io_imem_req_bits_vpn    (imem_req_vpn),
    .io_imem_resp_valid      (t4_imem_resp_valid),
    .io_imem_resp_bits_error (t4_imem_resp_err),
    .io_imem_resp_bits_ppn   (t4_imem_resp_ppn),
    .io_dmem_req_valid       (dmem_req_valid),
    .io_dmem_req_ready       (t4_dmem_req_ready),
    .io_dmem_req_bits_vpn    (dmem_req_vpn),
    .io_dmem_resp_valid      (t4_dmem_resp_valid),
    .io_dmem_resp_bits_error (t4_dmem_resp_err),
    .io_dmem_resp_bits_ppn   (t4_dmem_resp_ppn),
    .io_ptw_req_valid        (t4_ptw_req_valid),
    .io_ptw_req_ready        (ptw_req_ready),
    .io_ptw_req_bits_vpn     (t4_ptw_req_vpn),
    .io_ptw_resp_valid       (ptw_resp_valid),
    .io_ptw_resp_bits_error  (ptw_resp_err),
    .io_ptw_resp_bits_ppn    (ptw_resp_ppn),
    .io_busy                 (t4_busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s differs", tag);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle before sampling.
  task automatic applyStimulus(input logic iv, input logic dv,
                               input logic [VPN_W-1:0] ivpn, input logic [VPN_W-1:0] dvpn,
                               input logic pready, input logic pvalid, input logic perr,
                               input logic [PPN_W-1:0] pppn);
    @(negedge clk);
    imem_req_valid = iv;
    dmem_req_valid = dv;
    imem_req_vpn   = ivpn;
    dmem_req_vpn   = dvpn;
    ptw_req_ready  = pready;
    ptw_resp_valid = pvalid;
    ptw_resp_err   = perr;
    ptw_resp_ppn   = pppn;
    #1;
  endtask

  // Outputs expected whenever no grant and no response pulse is due.
  task automatic checkQuiet(input string tag, input logic busy_e, input logic preq_e,
                            input logic [VPN_W-1:0] vpn_e);
    checkOutput({tag, ".imem_ready"}, 64'(imem_req_ready), 64'(1'b0));
    checkOutput({tag, ".dmem_ready"}, 64'(dmem_req_ready), 64'(1'b0));
    checkOutput({tag, ".imem_resp"},  64'(imem_resp_valid), 64'(1'b0));
    checkOutput({tag, ".dmem_resp"},  64'(dmem_resp_valid), 64'(1'b0));
    checkOutput({tag, ".busy"},       64'(busy), 64'(busy_e));
    checkOutput({tag, ".ptw_valid"},  64'(ptw_req_valid), 64'(preq_e));
    if (preq_e) checkOutput({tag, ".ptw_vpn"}, 64'(ptw_req_vpn), 64'(vpn_e));
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    checkQuiet("reset", 1'b0, 1'b0, '0);
    reset = 1'b0;
    last_served = 1'b1;
  endtask

  // One complete walk. resp_k is the WAIT cycle (1-based) carrying the walker
  // response; 0 or beyond the watchdog means the walker stays silent.
  task automatic doWalk(input string tag, input logic iv, input logic dv,
                        input logic [VPN_W-1:0] ivpn, input logic [VPN_W-1:0] dvpn,
                        input logic hold, input int stall, input int resp_k,
                        input logic rerr, input logic [PPN_W-1:0] rppn,
                        input int late, input logic chk4);
    logic             exp_owner, kv_i, kv_d, exp_err, stray;
    logic [VPN_W-1:0] exp_vpn;
    logic [PPN_W-1:0] exp_ppn;
    int               eff;
    exp_owner = (iv && dv) ? ~last_served : dv;
    exp_vpn   = exp_owner ? dvpn : ivpn;
    kv_i      = hold ? iv : 1'b0;
    kv_d      = hold ? dv : 1'b0;
    if (resp_k >= 1 && resp_k <= TMO) begin
      eff = resp_k; exp_err = rerr; exp_ppn = rppn;
    end else begin
      eff = TMO; exp_err = 1'b1; exp_ppn = '0;
    end

    applyStimulus(iv, dv, ivpn, dvpn, 1'b0, 1'b0, 1'b0, '0);
    checkOutput({tag, ".grant_imem"}, 64'(imem_req_ready), 64'(!exp_owner));
    checkOutput({tag, ".grant_dmem"}, 64'(dmem_req_ready), 64'(exp_owner));
    checkOutput({tag, ".idle_busy"},  64'(busy), 64'(1'b0));
    checkOutput({tag, ".idle_ptw"},   64'(ptw_req_valid), 64'(1'b0));

    for (int s = 0; s <= stall; s++) begin
      applyStimulus(kv_i, kv_d, ivpn, dvpn, s == stall, 1'b0, 1'b0, '0);
      checkQuiet({tag, ".req"}, 1'b1, 1'b1, exp_vpn);
    end

    for (int w = 1; w <= eff; w++) begin
      applyStimulus(kv_i, kv_d, ivpn, dvpn, 1'b0, w == resp_k, rerr, rppn);
      checkQuiet({tag, ".wait"}, 1'b1, 1'b0, '0);
      if (chk4) checkOutput({tag, ".t4_wait"}, 64'(t4_imem_resp_valid | t4_dmem_resp_valid), 64'(1'b0));
    end

    stray = 1'($urandom_range(0, 1));
    applyStimulus(kv_i, kv_d, ivpn, dvpn, 1'b0, stray, ~exp_err, PPN_W'($urandom));
    checkOutput({tag, ".resp_imem"}, 64'(imem_resp_valid), 64'(!exp_owner));
    checkOutput({tag, ".resp_dmem"}, 64'(dmem_resp_valid), 64'(exp_owner));
    checkOutput({tag, ".resp_err"},  64'(exp_owner ? dmem_resp_err : imem_resp_err), 64'(exp_err));
    checkOutput({tag, ".resp_ppn"},  64'(exp_owner ? dmem_resp_ppn : imem_resp_ppn), 64'(exp_ppn));
    checkOutput({tag, ".resp_busy"}, 64'(busy), 64'(1'b1));
    checkOutput({tag, ".resp_rdy"},  64'(imem_req_ready | dmem_req_ready), 64'(1'b0));
    if (chk4) begin
      checkOutput({tag, ".t4_resp_imem"}, 64'(t4_imem_resp_valid), 64'(!exp_owner));
      checkOutput({tag, ".t4_resp_dmem"}, 64'(t4_dmem_resp_valid), 64'(exp_owner));
      checkOutput({tag, ".t4_resp_err"},  64'(exp_owner ? t4_dmem_resp_err : t4_imem_resp_err), 64'(exp_err));
      checkOutput({tag, ".t4_resp_ppn"},  64'(exp_owner ? t4_dmem_resp_ppn : t4_imem_resp_ppn), 64'(exp_ppn));
    end
    last_served = exp_owner;

    if (late > 0) begin
      for (int l = 1; l <= late + 1; l++) begin
        applyStimulus(1'b0, 1'b0, ivpn, dvpn, 1'b0, l == late, 1'b0, PPN_W'($urandom));
        checkQuiet({tag, ".late"}, 1'b0, 1'b0, '0);
      end
    end
  endtask

  // Directed scenarios first, then randomized walks against the model.
  initial begin
    logic [VPN_W-1:0] v;
    reset = 1'b1;
    last_served = 1'b1;
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    imem_req_vpn = '0; dmem_req_vpn = '0;
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_err = 1'b0; ptw_resp_ppn = '0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
      checkQuiet("por", 1'b0, 1'b0, '0);
      checkOutput("por.vpn",  64'(ptw_req_vpn), 64'(0));
      checkOutput("por.err",  64'(imem_resp_err | dmem_resp_err), 64'(1'b0));
      checkOutput("por.ppn",  64'(imem_resp_ppn | dmem_resp_ppn), 64'(0));
      checkOutput("por.t4busy", 64'(t4_busy), 64'(1'b0));
    end
    reset = 1'b0;

    $display("[TB] single imem walk");
    doWalk("basic", 1'b1, 1'b0, 20'h12345, 20'h0, 1'b0, 0, 1, 1'b0, 32'hABCD0, 0, 1'b0);

    $display("[TB] tie from reset, four alternating walks");
    doReset();
    for (int i = 0; i < 4; i++)
      doWalk("tie", 1'b1, 1'b1, VPN_W'($urandom), VPN_W'($urandom), 1'b1, 0, 2, 1'b0, PPN_W'($urandom), 0, 1'b0);

    $display("[TB] walker stalls five cycles");
    doWalk("stall", 1'b0, 1'b1, VPN_W'($urandom), VPN_W'($urandom), 1'b0, 5, 3, 1'b1, PPN_W'($urandom), 0, 1'b0);

    $display("[TB] watchdog expiry with late response");
    doWalk("timeout", 1'b1, 1'b0, VPN_W'($urandom), VPN_W'($urandom), 1'b0, 1, 0, 1'b0, PPN_W'($urandom), 3, 1'b0);

    $display("[TB] reset during WAIT");
    v = VPN_W'($urandom);
    doReset();
    applyStimulus(1'b1, 1'b0, v, '0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("abort.grant", 64'(imem_req_ready), 64'(1'b1));
    applyStimulus(1'b0, 1'b0, v, '0, 1'b1, 1'b0, 1'b0, '0);
    checkQuiet("abort.req", 1'b1, 1'b1, v);
    applyStimulus(1'b0, 1'b0, v, '0, 1'b0, 1'b0, 1'b0, '0);
    checkQuiet("abort.wait", 1'b1, 1'b0, '0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, v, '0, 1'b0, 1'b0, 1'b0, '0);
    checkQuiet("abort.rst", 1'b0, 1'b0, '0);
    reset = 1'b0;
    last_served = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, v, '0, 1'b0, i == 0, 1'b0, PPN_W'($urandom));
      checkQuiet("abort.drop", 1'b0, 1'b0, '0);
    end
    doWalk("abort.tie", 1'b1, 1'b1, VPN_W'($urandom), VPN_W'($urandom), 1'b0, 0, 1, 1'b0, PPN_W'($urandom), 0, 1'b0);

    $display("[TB] response coincides with watchdog expiry");
    doReset();
    doWalk("coincide4", 1'b1, 1'b0, VPN_W'($urandom), VPN_W'($urandom), 1'b0, 0, TMO4, 1'b0, 32'h0BEEF, 0, 1'b1);
    doWalk("coincide8", 1'b0, 1'b1, VPN_W'($urandom), VPN_W'($urandom), 1'b0, 0, TMO, 1'b0, 32'h0CAFE, 0, 1'b0);

    $display("[TB] randomized walks");
    for (int n = 0; n < 24; n++) begin
      int sel, gaps, stl, rk;
      sel  = int'($urandom_range(1, 3));
      gaps = int'($urandom_range(0, 2));
      stl  = int'($urandom_range(0, 3));
      rk   = int'($urandom_range(0, TMO));
      for (int g = 0; g < gaps; g++) begin
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, PPN_W'($urandom));
        checkQuiet("rand.gap", 1'b0, 1'b0, '0);
      end
      doWalk("rand", sel[0], sel[1], VPN_W'($urandom), VPN_W'($urandom), 1'($urandom_range(0, 1)),
             stl, rk, 1'($urandom_range(0, 1)), PPN_W'($urandom), 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptw_arbiter.md
# ptw_arbiter

Shares one page-table walker port between the instruction-side and data-side TLBs. Each TLB raises a walk request on a miss. The arbiter grants one request at a time using round-robin order and forwards it to the walker. It then returns the walker's response only to the TLB that owns the walk. A watchdog forces an error response if the walker never answers, so a TLB cannot hang on a lost walk.

## Interface
- VPN_W, default 20: virtual page number width.
- PPN_W, default 32: physical page number width; matches the TLB `resp_bits_ppn` width.
- TIMEOUT, default 255: number of WAIT cycles before a forced error response; 0 disables the watchdog.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- io_imem_req_valid  in  1  instruction TLB requests a walk.
- io_imem_req_ready  out  1  instruction TLB request accepted this cycle.
- io_imem_req_bits_vpn  in  VPN_W  VPN for the instruction-side walk.
- io_imem_resp_valid  out  1  one-cycle response pulse to the instruction TLB.
- io_imem_resp_bits_error  out  1  walk failed or timed out.
- io_imem_resp_bits_ppn  out  PPN_W  translated PPN.
- io_dmem_req_valid, io_dmem_req_ready, io_dmem_req_bits_vpn, io_dmem_resp_valid, io_dmem_resp_bits_error, io_dmem_resp_bits_ppn: same directions and widths as the imem ports, for the data TLB.
- io_ptw_req_valid  out  1  request to the walker.
- io_ptw_req_ready  in  1  walker accepts the request.
- io_ptw_req_bits_vpn  out  VPN_W  latched VPN.
- io_ptw_resp_valid  in  1  walker response valid.
- io_ptw_resp_bits_error  in  1  walker error flag.
- io_ptw_resp_bits_ppn  in  PPN_W  walker PPN.
- io_busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Only one walk is outstanding at a time.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester that is not `last`, the 1-bit record of the most recently served requester.
  - The granted requester's `req_ready` is driven combinationally high in that cycle. The valid && ready handshake latches its VPN and `owner`, and the FSM moves to REQ.
  - `req_ready` is 0 in every other state.
- REQ:
  - `io_ptw_req_valid` = 1 and `io_ptw_req_bits_vpn` = latched VPN.
  - When `io_ptw_req_ready` is sampled high, move to WAIT and clear the timer.
- WAIT:
  - The timer increments every cycle; its width is clog2(TIMEOUT+1).
  - When `io_ptw_resp_valid` is high, latch the error and PPN and move to RESP.
  - Otherwise, if TIMEOUT≠0 and timer == TIMEOUT-1, latch error=1 and ppn=0 and move to RESP.
  - If a response arrives in the same cycle the timeout expires, the real response wins.
- RESP:
  - `<owner>_resp_valid` = 1 for exactly one cycle; the other requester's `resp_valid` = 0.
  - The latched error and PPN are driven on both requesters' resp_bits; they are meaningful only at the owner.
  - Set `last` = owner and return to IDLE.
- A walker response arriving in any state other than WAIT is ignored and discarded. This covers late responses after a timeout.
- A requester that drops `req_valid` before it is granted loses nothing; no state changes.

## Timing
- Reset values:
  - state = IDLE, timer = 0, `last` = dmem, so imem wins the first tie.
  - Latched VPN, PPN and error = 0.
  - All valid and ready outputs = 0; `io_busy` = 0.
- Asserting reset mid-walk aborts the walk. No response is delivered to the owner, and any later walker response is dropped.
- Latency, with the request accepted in cycle t:
  - `io_ptw_req_valid` is high from cycle t+1.
  - With the walker ready at t+1, the FSM is in WAIT at t+2.
  - A walker response in cycle r produces the owner's `resp_valid` at r+1.
  - The minimum path is accept t, walker response t+2, owner response t+3. The FSM is back in IDLE at t+4, and the next grant is possible at t+4.
- `io_ptw_req_valid` stays high, with a stable VPN, until the walker accepts it.
- Timeout response: `resp_valid` is asserted TIMEOUT+1 cycles after the WAIT entry cycle.

## Test plan
- Single imem request, vpn=0x12345; walker ready immediately and responds one cycle later with ppn=0xABCD0, error=0 -> imem `resp_valid` pulse at t+3 with ppn=0xABCD0; dmem `resp_valid` stays 0.
- imem and dmem both valid from reset -> imem granted first; once that walk completes, dmem granted at the next IDLE. Repeat with both held valid for 4 walks -> grants alternate imem, dmem, imem, dmem.
- Walker holds `io_ptw_req_ready` low for 5 cycles -> `io_ptw_req_valid` and the VPN stay stable for all 5 cycles; the walk completes normally afterwards.
- TIMEOUT=8, walker never responds -> owner receives error=1, ppn=0 9 cycles after WAIT entry. A walker response 3 cycles later is ignored, and no second pulse appears.
- Reset asserted while in WAIT; walker then responds -> no `resp_valid` on either port, `io_busy`=0, and the next tie grants imem.
- Walker response coincides with timeout expiry (TIMEOUT=4, response on the 4th WAIT cycle) -> the real ppn is delivered with error=0.
